scarv_cop_palu_addsub_mc: RTL and testbench

- Multi-cycle, parametrised packed add/subtract unit for the coprocessor PALU.
- Generalises the single-cycle packed adder in three ways:
  - operand width W is a parameter;
  - the carry chain is evaluated CHUNK bits per cycle, trading latency for area;
  - adds an unsigned-saturating mode and a per-lane carry-out vector.
- Sits between the PALU operand register stage and PALU writeback, with valid/ready handshakes on both sides.

---
 rtl/scarv_cop_palu_addsub_mc.sv | 139 +++++++++++++
 tb/tb_scarv_cop_palu_addsub_mc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_palu_addsub_mc.sv
// Multi-cycle packed add/subtract for the PALU: ripples CHUNK bits per cycle,
// with a configurable lane width, optional unsigned saturation and per-lane carry-out.
module scarv_cop_palu_addsub_mc #(
    parameter int W     = 32,
    parameter int CHUNK = 8,
    parameter int PWW   = $clog2(W)
) (
    input  logic           g_clk,
    input  logic           g_resetn,
    input  logic           flush,
    input  logic           ivalid,
    output logic           iready,
    input  logic [W-1:0]   lhs,
    input  logic [W-1:0]   rhs,
    input  logic [PWW-1:0] pw,
    input  logic           sub,
    input  logic           sat,
    output logic           ovalid,
    input  logic           oready,
    output logic [W-1:0]   result,
    output logic [W-1:0]   c_out
);

    localparam int N  = W / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt;
    logic           carry_r, carry_nx;
    logic [W-1:0]   op_a, op_b;
    logic           sub_r, sat_r;
    logic [PWW-1:0] lw_m1_r, lw_dec;
    logic [W-1:0]   result_r, c_out_r;
    logic [W-1:0]   res_nx, cout_nx, sat_res;
    logic [PWW-1:0] idx, msb;
    logic           cy, co, last, accept, step;

    assign last   = (cnt == CW'(N - 1));
    assign accept = (state_q == IDLE) && ivalid && !flush;
    assign step   = (state_q == RUN) && !flush;
    assign result = result_r;
    assign c_out  = c_out_r;

    // Lane width minus one; doubles as the mask of in-lane bit positions.
    always_comb begin
        lw_dec = PWW'(W - 1);
        if (pw != '0 && (pw & (pw - PWW'(1))) == '0) begin
            for (int k = 0; k < PWW; k++) begin
                if (pw[k]) lw_dec = PWW'((W >> k) - 1);
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        iready  = 1'b0;
        ovalid  = 1'b0;
        case (state_q)
            IDLE: begin
                iready = 1'b1;
                if (ivalid && !flush) state_d = RUN;
            end
            RUN: begin
                if (flush)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                ovalid = 1'b1;
                if (flush || oready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One chunk of ripple carry, then saturation using the completed carry vector.
    always_comb begin
        res_nx  = result_r;
        cout_nx = c_out_r;
        cy      = carry_r;
        co      = 1'b0;
        idx     = '0;
        msb     = '0;
        for (int j = 0; j < CHUNK; j++) begin
            idx = PWW'(int'(cnt) * CHUNK + j);
            if ((idx & lw_m1_r) == '0) cy = sub_r;
            res_nx[idx] = op_a[idx] ^ op_b[idx] ^ cy;
            co = (op_a[idx] & op_b[idx]) | (cy & (op_a[idx] ^ op_b[idx]));
            if ((idx & lw_m1_r) == lw_m1_r) begin
                cout_nx[idx] = co;
                cy           = sub_r;
            end else begin
                cy = co;
            end
        end
        carry_nx = cy;
        sat_res  = res_nx;
        for (int i = 0; i < W; i++) begin
            msb = PWW'(i) | lw_m1_r;
            if (sat_r && !sub_r && cout_nx[msb])  sat_res[i] = 1'b1;
            if (sat_r && sub_r  && !cout_nx[msb]) sat_res[i] = 1'b0;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt      <= '0;
            carry_r  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            sub_r    <= 1'b0;
            sat_r    <= 1'b0;
            lw_m1_r  <= '0;
            result_r <= '0;
            c_out_r  <= '0;
        end else if (accept) begin
            op_a    <= lhs;
            op_b    <= sub ? ~rhs : rhs;
            sub_r   <= sub;
            sat_r   <= sat;
            lw_m1_r <= lw_dec;
            carry_r <= sub;
            cnt     <= '0;
            c_out_r <= '0;
        end else if (step) begin
            result_r <= last ? sat_res : res_nx;
            c_out_r  <= cout_nx;
            carry_r  <= carry_nx;
            cnt      <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_scarv_cop_palu_addsub_mc.sv
// Directed bench for the packed add/sub unit: 32-bit/8-bit-chunk and 64-bit/16-bit-chunk instances.
module tb_scarv_cop_palu_addsub_mc;

    logic        g_clk = 1'b0, g_resetn = 1'b1, flush = 1'b0;
    logic        ivalid = 1'b0, oready = 1'b0, sub = 1'b0, sat = 1'b0;
    logic        iready, ovalid;
    logic [31:0] lhs = '0, rhs = '0, result, c_out;
    logic [4:0]  pw = '0;

    logic        ivalid_w = 1'b0, oready_w = 1'b0, iready_w, ovalid_w;
    logic [63:0] lhs_w = '0, rhs_w = '0, result_w, c_out_w;
    logic [5:0]  pw_w = '0;

    int total = 0, bad = 0;
    logic [31:0] held;

    always #5 g_clk = ~g_clk;

    scarv_cop_palu_addsub_mc #(.W(32), .CHUNK(8)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .ivalid(ivalid), .iready(iready),
        .lhs(lhs), .rhs(rhs), .pw(pw), .sub(sub), .sat(sat), .ovalid(ovalid), .oready(oready),
        .result(result), .c_out(c_out)
    );

    scarv_cop_palu_addsub_mc #(.W(64), .CHUNK(16)) dut_w (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(1'b0), .ivalid(ivalid_w), .iready(iready_w),
        .lhs(lhs_w), .rhs(rhs_w), .pw(pw_w), .sub(1'b0), .sat(1'b0), .ovalid(ovalid_w),
        .oready(oready_w), .result(result_w), .c_out(c_out_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then scramble the inputs to show they are not re-sampled.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] p, input logic s, input logic t,
                         input logic [31:0] exp_res, input logic [31:0] exp_cout, input bit hold);
        int n;
        chk({tag, "_iready"}, iready, 1);
        lhs = a; rhs = b; pw = p; sub = s; sat = t; ivalid = 1'b1;
        @(posedge g_clk); #1;
        ivalid = 1'b0; lhs = 32'hDEADBEEF; rhs = 32'h12345678; pw = 5'b00101; sub = ~s; sat = ~t;
        n = 0;
        while (!ovalid && n < 20) begin
            @(posedge g_clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_cout"}, c_out, exp_cout);
        if (!hold) begin
            oready = 1'b1;
            @(posedge g_clk); #1;
            oready = 1'b0;
            chk({tag, "_ovalid_drop"}, ovalid, 0);
        end
    endtask

    initial begin
        int n;
        #1 g_resetn = 1'b0;
        #7;
        chk("rst_iready", iready, 1);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", c_out, 0);
        #4 g_resetn = 1'b1;
        @(posedge g_clk); #1;

        do_op("add_full", 32'h7FFFFFFF, 32'h00000001, 5'b00001, 1'b0, 1'b0, 32'h80000000, 32'h00000000, 1'b0);
        do_op("sub_bytes", 32'h00010203, 32'h01010101, 5'b00100, 1'b1, 1'b0, 32'hFF000102, 32'h00808080, 1'b0);
        do_op("sat_sub_half", 32'h00050003, 32'h00060001, 5'b00010, 1'b1, 1'b1, 32'h00000002, 32'h00008000, 1'b0);
        // Each 2-bit lane computes 3+1, which wraps to 0 with a carry.
        do_op("add_2bit", 32'hFFFFFFFF, 32'h55555555, 5'b10000, 1'b0, 1'b0, 32'h00000000, 32'hAAAAAAAA, 1'b0);
        do_op("add_nibble", 32'hFFFFFFFF, 32'h55555555, 5'b01000, 1'b0, 1'b0, 32'h44444444, 32'h88888888, 1'b0);
        do_op("pw_zero", 32'hFFFFFFFF, 32'h00000001, 5'b00000, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 1'b0);
        do_op("pw_multi", 32'h0000FFFF, 32'h00000001, 5'b00110, 1'b0, 1'b0, 32'h00010000, 32'h00000000, 1'b0);

        // Backpressure: result held in DONE while new requests are ignored.
        do_op("sat_add_half", 32'hFFF00001, 32'h00200002, 5'b00010, 1'b0, 1'b1, 32'hFFFF0003, 32'h80000000, 1'b1);
        held = result;
        ivalid = 1'b1; lhs = 32'h11111111; rhs = 32'h22222222; pw = 5'b00001; sub = 1'b0; sat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge g_clk); #1;
            chk("bp_ovalid", ovalid, 1);
            chk("bp_iready", iready, 0);
            chk("bp_result", result, held);
        end
        ivalid = 1'b0; oready = 1'b1;
        @(posedge g_clk); #1;
        oready = 1'b0;
        chk("bp_release_ovalid", ovalid, 0);
        chk("bp_release_iready", iready, 1);
        @(posedge g_clk); #1;
        chk("bp_no_ghost", iready, 1);

        // Flush during the second RUN cycle.
        lhs = 32'h00000005; rhs = 32'h00000003; pw = 5'b00001; ivalid = 1'b1;
        @(posedge g_clk); #1;
        ivalid = 1'b0;
        @(posedge g_clk); #1;
        flush = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0;
        chk("flush_iready", iready, 1);
        chk("flush_ovalid", ovalid, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge g_clk); #1;
            if (ovalid) n++;
        end
        chk("flush_no_result", n, 0);

        // Flush in IDLE drops the simultaneous request.
        flush = 1'b1; ivalid = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0; ivalid = 1'b0;
        chk("flush_idle_iready", iready, 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge g_clk); #1;
            if (ovalid) n++;
        end
        chk("flush_idle_dropped", n, 0);

        // Async reset in the middle of RUN.
        lhs = 32'h0F0F0F0F; rhs = 32'h01010101; ivalid = 1'b1;
        @(posedge g_clk); #1;
        ivalid = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b0;
        #1;
        chk("areset_iready", iready, 1);
        chk("areset_ovalid", ovalid, 0);
        chk("areset_result", result, 0);
        chk("areset_cout", c_out, 0);
        #2 g_resetn = 1'b1;
        @(posedge g_clk); #1;
        do_op("post_reset", 32'h00000001, 32'h00000001, 5'b00001, 1'b0, 1'b0, 32'h00000002, 32'h00000000, 1'b0);

        // 64-bit instance, 2-bit lanes.
        chk("w64_iready", iready_w, 1);
        lhs_w = 64'hFFFFFFFF_FFFFFFFF; rhs_w = 64'h55555555_55555555; pw_w = 6'b100000; ivalid_w = 1'b1;
        @(posedge g_clk); #1;
        ivalid_w = 1'b0;
        n = 0;
        while (!ovalid_w && n < 20) begin
            @(posedge g_clk); #1;
            n++;
        end
        chk("w64_latency", n, 4);
        chk("w64_result", result_w, 64'h0);
        chk("w64_cout", c_out_w, 64'hAAAAAAAA_AAAAAAAA);
        oready_w = 1'b1;
        @(posedge g_clk); #1;
        oready_w = 1'b0;
        chk("w64_ovalid_drop", ovalid_w, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
